// File: rtl/lsu_pkg.sv
// lsu_pkg: shared access-size codes, FSM encoding and legality check for the load/store unit
package lsu_pkg;
  localparam int TIMEOUT_DEFAULT = 16;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_e;
  function automatic logic access_ok(input logic rd, input logic wr, input logic [2:0] f3, input logic [1:0] lsb);
    logic legal;
    legal = wr ? (f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    return !(rd && wr) && legal && !(f3[1:0] == 2'b01 && lsb[0]) && !(f3[1:0] == 2'b10 && lsb != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: load lane extraction/extension and store replication/byte-enable generation
module lsu_lane_align import lsu_pkg::*; (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lsb_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_i[{lsb_i, 3'b000} +: 8];
    h = lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ldata_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
              funct3_i == F3_H  ? {{16{h[15]}}, h} :
              funct3_i == F3_BU ? {24'b0, b} :
              funct3_i == F3_HU ? {16'b0, h} : rdata_i;
    be_o = funct3_i[1:0] == 2'b00 ? 4'b0001 << lsb_i :
           funct3_i[1:0] == 2'b01 ? (lsb_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_o = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
              funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store bus master with alignment checks and ack timeout
module load_store_unit import lsu_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  lsb_q;
  logic        done_q, err_q, req_q, we_q, idle, ok;
  logic [3:0]  be_q, al_be;
  logic [31:0] addr_q, wdata_q, ld_q, al_wd, al_ld;
  assign idle = state_q == S_IDLE;
  assign ok = access_ok(mem_read, mem_write, funct3, addr[1:0]);
  // Live inputs feed the aligner while sampling; the captured access drives it for the load return
  lsu_lane_align u_align (
    .funct3_i(idle ? funct3 : f3_q),
    .lsb_i   (idle ? addr[1:0] : lsb_q),
    .wdata_i (store_data),
    .rdata_i (bus_rdata),
    .be_o    (al_be),
    .wdata_o (al_wd),
    .ldata_o (al_ld)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      lsb_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (mem_read || mem_write) begin
          f3_q    <= funct3;
          lsb_q   <= addr[1:0];
          cnt_q   <= '0;
          addr_q  <= {addr[31:2], 2'b00};
          we_q    <= ok && mem_write;
          be_q    <= (ok && mem_write) ? al_be : 4'b0000;
          wdata_q <= mem_write ? al_wd : '0;
          req_q   <= ok;
          err_q   <= !ok;
          state_q <= ok ? S_REQ : S_ERR;
        end
        S_REQ: if (bus_ack) begin
          req_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
          if (!we_q) ld_q <= al_ld;
        end else if (cnt_q == CNT_LAST) begin
          req_q   <= 1'b0;
          err_q   <= 1'b1;
          state_q <= S_ERR;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
  assign busy      = !idle;
  assign done      = done_q;
  assign err       = err_q;
  assign load_data = ld_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a behavioural model
module tb_load_store_unit;
  localparam int TO = 16;
  logic clk = 0, rst = 0, mem_read = 0, mem_write = 0, bus_ack = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, store_data = 0, bus_rdata = 0;
  logic busy, done, err, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] ld_exp = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic bit m_ok(bit rd, bit wr, int f3, int unsigned a);
    int unsigned sz;
    if (rd && wr) return 0;
    if (wr && f3 > 2) return 0;
    if (rd && !(f3 inside {0, 1, 2, 4, 5})) return 0;
    sz = 1 << (f3 % 4);
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] m_load(int f3, int unsigned a, logic [31:0] rdata);
    int unsigned sh, bits, v;
    if (f3 == 2) return rdata;
    sh = (a % 4) * 8;
    bits = (f3 % 4 == 0) ? 8 : 16;
    v = (rdata >> sh) & ((1 << bits) - 1);
    if (f3 < 4 && v >= (1 << (bits - 1))) v = v - (1 << bits);
    return v;
  endfunction

  function automatic logic [3:0] m_be(int f3, int unsigned a);
    if (f3 == 2) return 4'd15;
    return 4'(((f3 == 0) ? 1 : 3) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(int f3, logic [31:0] sd);
    if (f3 == 0) return (sd & 32'hFF) * 32'h0101_0101;
    if (f3 == 1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  // Drives one request from a negedge, plays the bus slave, and reports what was observed
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdat, input int ack_after,
                        output int reqc, output int dn, output int er, output bit e0, output bit stable,
                        output logic [31:0] baddr, output logic [31:0] bwd, output logic [3:0] bbe,
                        output logic bwe);
    reqc = 0; dn = 0; er = 0; e0 = 0; stable = 1; baddr = 0; bwd = 0; bbe = 0; bwe = 0;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!busy) break;
      if (done) dn++;
      if (err) begin er++; if (c == 0) e0 = 1; end
      if (bus_req) begin
        if (reqc == 0) begin baddr = bus_addr; bwd = bus_wdata; bbe = bus_be; bwe = bus_we; end
        else if ({bus_addr, bus_wdata, bus_be, bus_we} !== {baddr, bwd, bbe, bwe}) stable = 0;
        reqc++;
        bus_ack = reqc > ack_after;
        bus_rdata = bus_ack ? rdat : $urandom;
      end else begin
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
    end
    bus_ack = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #2;
    n_cmp++; if ({busy, done, err, bus_req, bus_we} !== 5'b0) begin n_bad++; $display("FAIL reset_status got=%b exp=00000", {busy, done, err, bus_req, bus_we}); end
    n_cmp++; if ({bus_be, bus_addr, bus_wdata, load_data} !== '0) begin n_bad++; $display("FAIL reset_bus got be=%h addr=%h wdata=%h ld=%h exp all 0", bus_be, bus_addr, bus_wdata, load_data); end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_lb();
    int reqc, dn, er; bit e0, st; logic [31:0] ba, bw; logic [3:0] be; logic we;
    access(1, 0, 3'b000, 32'h103, 0, 32'h80FF_1234, 2, reqc, dn, er, e0, st, ba, bw, be, we);
    ld_exp = 32'hFFFF_FF80;
    n_cmp++; if (dn !== 1 || er !== 0) begin n_bad++; $display("FAIL lb_pulses got done=%0d err=%0d exp 1/0", dn, er); end
    n_cmp++; if (reqc !== 3) begin n_bad++; $display("FAIL lb_req_cycles got=%0d exp=3", reqc); end
    n_cmp++; if (load_data !== ld_exp) begin n_bad++; $display("FAIL lb_load_data got=%h exp=%h", load_data, ld_exp); end
    n_cmp++; if ({ba, be, we, st} !== {32'h100, 4'b0000, 1'b0, 1'b1}) begin n_bad++; $display("FAIL lb_bus got addr=%h be=%b we=%b stable=%b exp 100/0000/0/1", ba, be, we, st); end
  endtask

  task automatic test_sh();
    int reqc, dn, er; bit e0, st; logic [31:0] ba, bw; logic [3:0] be; logic we;
    access(0, 1, 3'b001, 32'h102, 32'h0000_BEEF, $urandom, 1, reqc, dn, er, e0, st, ba, bw, be, we);
    n_cmp++; if ({be, bw, ba, we} !== {4'b1100, 32'hBEEF_BEEF, 32'h100, 1'b1}) begin n_bad++; $display("FAIL sh_bus got be=%b wdata=%h addr=%h we=%b exp 1100/beefbeef/100/1", be, bw, ba, we); end
    n_cmp++; if (dn !== 1 || er !== 0 || reqc !== 2 || !st) begin n_bad++; $display("FAIL sh_flow got done=%0d err=%0d reqc=%0d stable=%b exp 1/0/2/1", dn, er, reqc, st); end
    n_cmp++; if (load_data !== ld_exp) begin n_bad++; $display("FAIL sh_load_data_kept got=%h exp=%h", load_data, ld_exp); end
  endtask

  task automatic test_misaligned();
    int reqc, dn, er; bit e0, st; logic [31:0] ba, bw; logic [3:0] be; logic we;
    access(1, 0, 3'b010, 32'h202, 0, $urandom, 0, reqc, dn, er, e0, st, ba, bw, be, we);
    n_cmp++; if (er !== 1 || !e0 || dn !== 0) begin n_bad++; $display("FAIL lw_misaligned got err=%0d first=%b done=%0d exp 1/1/0", er, e0, dn); end
    n_cmp++; if (reqc !== 0) begin n_bad++; $display("FAIL lw_misaligned_req got=%0d exp=0", reqc); end
  endtask

  task automatic test_timeout();
    int reqc, dn, er; bit e0, st; logic [31:0] ba, bw, rd; logic [3:0] be; logic we;
    access(1, 0, 3'b101, 32'h10, 0, $urandom, 1000, reqc, dn, er, e0, st, ba, bw, be, we);
    n_cmp++; if (reqc !== TO || er !== 1 || dn !== 0) begin n_bad++; $display("FAIL timeout got reqc=%0d err=%0d done=%0d exp %0d/1/0", reqc, er, dn, TO); end
    n_cmp++; if (load_data !== ld_exp) begin n_bad++; $display("FAIL timeout_load_data got=%h exp=%h", load_data, ld_exp); end
    rd = $urandom | 32'h0000_8000;
    access(1, 0, 3'b101, 32'h12, 0, rd, TO - 1, reqc, dn, er, e0, st, ba, bw, be, we);
    ld_exp = m_load(5, 32'h12, rd);
    n_cmp++; if (reqc !== TO || er !== 0 || dn !== 1) begin n_bad++; $display("FAIL late_ack got reqc=%0d err=%0d done=%0d exp %0d/0/1", reqc, er, dn, TO); end
    n_cmp++; if (load_data !== ld_exp) begin n_bad++; $display("FAIL late_ack_load_data got=%h exp=%h", load_data, ld_exp); end
  endtask

  task automatic test_both();
    int reqc, dn, er; bit e0, st; logic [31:0] ba, bw; logic [3:0] be; logic we;
    access(1, 1, 3'b010, 32'h0, $urandom, $urandom, 0, reqc, dn, er, e0, st, ba, bw, be, we);
    n_cmp++; if (er !== 1 || dn !== 0 || reqc !== 0) begin n_bad++; $display("FAIL both_req got err=%0d done=%0d reqc=%0d exp 1/0/0", er, dn, reqc); end
  endtask

  task automatic test_rst_mid();
    int dn = 0;
    mem_read = 1; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1 mem_read = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus_req !== 1) begin n_bad++; $display("FAIL rst_mid_pre got bus_req=%b exp=1", bus_req); end
    #2 rst = 1;
    #1;
    n_cmp++; if ({bus_req, busy, load_data} !== '0) begin n_bad++; $display("FAIL rst_mid_async got req=%b busy=%b ld=%h exp 0/0/0", bus_req, busy, load_data); end
    ld_exp = 0;
    @(negedge clk) rst = 0;
    for (int c = 0; c < 5; c++) begin
      bus_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done || err || busy) dn++;
    end
    bus_ack = 0;
    n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL rst_mid_after got active_cycles=%0d exp=0", dn); end
  endtask

  task automatic test_back_to_back();
    int reqc, dn, er; bit e0, st; logic [31:0] ba, bw, rd; logic [3:0] be; logic we;
    longint t0, t1;
    for (int i = 0; i < 3; i++) begin
      t0 = $time;
      rd = $urandom;
      access(1, 0, 3'b000, 32'h300 + 32'(i), 0, rd, 0, reqc, dn, er, e0, st, ba, bw, be, we);
      t1 = $time;
      ld_exp = m_load(0, 32'h300 + i, rd);
      n_cmp++; if (t1 - t0 != 30 || dn !== 1) begin n_bad++; $display("FAIL b2b_%0d got period=%0d done=%0d exp 30/1", i, t1 - t0, dn); end
      n_cmp++; if (load_data !== ld_exp) begin n_bad++; $display("FAIL b2b_data_%0d got=%h exp=%h", i, load_data, ld_exp); end
    end
  endtask

  task automatic test_random();
    int reqc, dn, er, aa, f3, r; bit e0, st, rdq, wrq, ok; logic [31:0] ba, bw, a, sd, rd; logic [3:0] be; logic we;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      rdq = r <= 5; wrq = (r == 0) || (r > 5);
      f3 = $urandom_range(0, 7);
      a = $urandom; sd = $urandom; rd = $urandom;
      aa = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 3);
      access(rdq, wrq, 3'(f3), a, sd, rd, aa, reqc, dn, er, e0, st, ba, bw, be, we);
      ok = m_ok(rdq, wrq, f3, a);
      if (!ok) begin
        n_cmp++; if (er !== 1 || dn !== 0 || reqc !== 0) begin n_bad++; $display("FAIL rnd_illegal_%0d rd=%b wr=%b f3=%0d a=%h got err=%0d done=%0d reqc=%0d exp 1/0/0", i, rdq, wrq, f3, a, er, dn, reqc); end
      end else begin
        if (aa < TO && rdq) ld_exp = m_load(f3, a, rd);
        n_cmp++; if (reqc !== (aa < TO ? aa + 1 : TO) || dn !== int'(aa < TO) || er !== int'(aa >= TO)) begin n_bad++; $display("FAIL rnd_flow_%0d ack_after=%0d got reqc=%0d done=%0d err=%0d", i, aa, reqc, dn, er); end
        n_cmp++; if ({ba, be, we, st} !== {a & ~32'h3, wrq ? m_be(f3, a) : 4'b0, wrq, 1'b1}) begin n_bad++; $display("FAIL rnd_bus_%0d got addr=%h be=%b we=%b stable=%b exp addr=%h be=%b we=%b", i, ba, be, we, st, a & ~32'h3, wrq ? m_be(f3, a) : 4'b0, wrq); end
        if (wrq) begin
          n_cmp++; if (bw !== m_wdata(f3, sd)) begin n_bad++; $display("FAIL rnd_wdata_%0d got=%h exp=%h", i, bw, m_wdata(f3, sd)); end
        end
      end
      n_cmp++; if (load_data !== ld_exp) begin n_bad++; $display("FAIL rnd_load_data_%0d got=%h exp=%h", i, load_data, ld_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_misaligned();
    test_timeout();
    test_both();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, max cycles waiting for bus_ack before abort (2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: mem_read  input  1  load request from decode (decode's mem_read_control).
REQ-005 SHALL have port: mem_write  input  1  store request from decode (decode's mem_write_control).
REQ-006 SHALL have port: funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port: addr  input  32  effective byte address (ALU result).
REQ-008 SHALL have port: store_data  input  32  rs2 value for stores.
REQ-009 SHALL have port: busy  output  1  high while a transaction is in progress; new requests ignored.
REQ-010 SHALL have port: done  output  1  one-cycle pulse on successful completion.
REQ-011 SHALL have port: err  output  1  one-cycle pulse on misaligned, illegal or timed-out access.
REQ-012 SHALL have port: load_data  output  32  extended load result, valid with done for loads, held until next done.
REQ-013 SHALL have port: bus_req / bus_we  output  1 / 1  bus request, write enable.
REQ-014 SHALL have port: bus_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-015 SHALL have port: bus_wdata / bus_be  output  32 / 4  write data, byte enables.
REQ-016 SHALL have port: bus_ack / bus_rdata  input  1 / 32  bus completion, read data valid with ack.

Function
REQ-017 SHALL implement FSM IDLE, REQ, DONE, ERR; busy=1 in REQ, DONE, ERR.
REQ-018 SHALL, in IDLE, sample mem_read/mem_write/funct3/addr/store_data into registers when either request is high.
REQ-019 SHALL go IDLE->ERR when both requests high, funct3 illegal for the direction (load: 011,110,111; store: >010), H/HU with addr[0]=1, or W with addr[1:0]!=0; no bus_req issued.
REQ-020 SHALL otherwise go IDLE->REQ; bus_req asserts the cycle after sampling, one-cycle minimum latency.
REQ-021 SHALL hold bus_req, bus_we, bus_addr, bus_wdata, bus_be stable in REQ until bus_ack sampled high.
REQ-022 SHALL, on bus_ack in REQ, deassert bus_req next cycle, enter DONE, pulse done for one cycle, return to IDLE.
REQ-023 SHALL ignore bus_ack outside REQ.
REQ-024 SHALL count cycles in REQ; on count == TIMEOUT_CYCLES without ack, drop bus_req, enter ERR.
REQ-025 SHALL pulse err for one cycle in ERR and return to IDLE; load_data unchanged on error.
REQ-026 SHALL on loads select lane addr[1:0] (B) or addr[1] (H); B/H sign-extend, BU/HU zero-extend, W pass through.
REQ-027 SHALL on stores set bus_be = 0001<<addr[1:0] (B), 0011<<(2*addr[1]) (H), 1111 (W); replicate byte/halfword across bus_wdata.
REQ-028 SHALL drive bus_be=0000 and bus_we=0 on loads.
REQ-029 SHALL accept a new request in the IDLE cycle immediately following DONE/ERR (back-to-back throughput one access per 3 cycles plus bus wait).

Reset
REQ-030 SHALL on rst force IDLE, counter 0, busy/done/err/bus_req/bus_we 0, bus_be 0, bus_addr/bus_wdata/load_data 0, immediately (asynchronous).
REQ-031 SHALL abandon a transaction in progress when rst asserts mid-REQ; no done/err pulse follows.

Structure
REQ-032 SHALL place funct3 size constants, FSM state encoding and TIMEOUT default in shared package lsu_pkg.
REQ-033 SHALL use one combinational sub-module lsu_lane_align for load extraction/extension and store replication/byte-enable generation.

Verification
REQ-034 SHALL cover: LB addr=0x103, bus_rdata=0x80FF_1234, ack after 2 cycles -> done, load_data=0xFFFF_FF80.
REQ-035 SHALL cover: SH addr=0x102, store_data=0x0000_BEEF -> bus_be=1100, bus_wdata=0xBEEF_BEEF, bus_addr=0x100, bus_we=1.
REQ-036 SHALL cover: LW addr=0x202 -> err pulse 1 cycle after request, bus_req never asserted.
REQ-037 SHALL cover: LHU addr=0x10, no ack for 16 cycles -> bus_req drops, err pulse, load_data unchanged.
REQ-038 SHALL cover: mem_read and mem_write both high -> err; rst asserted mid-REQ -> bus_req and busy 0 same cycle, no done.
